fetch_unit: RTL

//  Instruction fetch stage, directly upstream of instruction decode. Owns the PC,

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads over a req/valid handshake,
// and hands one registered instruction plus its PC to decode through a 1-entry skid buffer.
module fetch_unit #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                inst_valid,
  output logic [31:0]         inst,
  output logic [PC_WIDTH-1:0] inst_pc
);

  localparam int unsigned IW = 32;

  typedef enum logic [1:0] {
    S_FETCH      = 2'd0,
    S_WAIT_SPACE = 2'd1,
    S_DRAIN      = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                req_q, req_d;
  logic                out_v_q, out_v_d;
  logic [IW-1:0]       inst_q, inst_d;
  logic [PC_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                skid_v_q, skid_v_d;
  logic [IW-1:0]       skid_q, skid_d;

  logic resp;
  logic take;
  logic advance;

  assign resp    = req_q && imem_valid;
  assign take    = resp && (state_q == S_FETCH);
  assign advance = out_v_q && !stall;

  // Next-state: branch flush first, otherwise output advance, capture and PC step.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    out_v_d   = out_v_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    skid_v_d  = skid_v_q;
    skid_d    = skid_q;
    if (branch_taken) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
      pc_d     = branch_target & ~PC_WIDTH'(3);
      state_d  = (req_q && !imem_valid) ? S_DRAIN : S_FETCH;
    end else begin
      if (advance) begin
        // Skid entry is always the sequential successor of the output entry.
        if (skid_v_q) begin
          inst_d    = skid_q;
          inst_pc_d = inst_pc_q + PC_WIDTH'(PC_STEP);
          skid_v_d  = 1'b0;
        end else if (take) begin
          inst_d    = imem_rdata;
          inst_pc_d = addr_q;
        end else begin
          out_v_d = 1'b0;
        end
      end else if (take) begin
        if (!out_v_q) begin
          out_v_d   = 1'b1;
          inst_d    = imem_rdata;
          inst_pc_d = addr_q;
        end else begin
          skid_v_d = 1'b1;
          skid_d   = imem_rdata;
        end
      end
      if (take) pc_d = pc_q + PC_WIDTH'(PC_STEP);
      case (state_q)
        S_DRAIN: if (resp) state_d = S_FETCH;
        default: state_d = (out_v_d && skid_v_d) ? S_WAIT_SPACE : S_FETCH;
      endcase
    end
    req_d  = (state_d != S_WAIT_SPACE);
    // A draining request keeps its old address until the discarded response arrives.
    addr_d = (state_d == S_DRAIN) ? addr_q : pc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      req_q     <= 1'b0;
      out_v_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      skid_v_q  <= 1'b0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      out_v_q   <= out_v_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      skid_v_q  <= skid_v_d;
      skid_q    <= skid_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = out_v_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule
